// File: rtl/dmem_line_pkg.sv
// Shared types and geometry helpers for the data-memory line responder.
package dmem_line_pkg;

    localparam int unsigned WordW     = 32;
    localparam int unsigned ByteLanes = 4;

    typedef enum logic [1:0] {
        StIdle,
        StResp,
        StWb,
        StFill
    } dmem_state_t;

    // Number of byte-offset bits covered by one line.
    function automatic int unsigned line_byte_w(input int unsigned beats,
                                                input int unsigned beat_w);
        return $clog2(beats * beat_w / 8);
    endfunction

    // Word-offset width: byte offset minus the two ignored byte bits.
    function automatic int unsigned word_off_w(input int unsigned beats,
                                               input int unsigned beat_w);
        return line_byte_w(beats, beat_w) - 2;
    endfunction

    function automatic int unsigned tag_w(input int unsigned beats, input int unsigned beat_w);
        return 32 - line_byte_w(beats, beat_w);
    endfunction

endpackage

// File: rtl/dmem_line_responder_line_merge.sv
// Combinational byte-lane merge of a core write into a line, plus read word select.
module line_merge
    import dmem_line_pkg::*;
#(
    parameter int unsigned LineW = 256,
    parameter int unsigned OffW  = 3
) (
    input  logic [LineW-1:0] line_i,
    input  logic [OffW-1:0]  word_off_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [LineW-1:0] line_o,
    output logic [31:0]      rword_o
);

    logic [31:0] word_base;

    assign word_base = 32'(word_off_i) * WordW;
    assign rword_o   = line_i[word_base +: WordW];

    // Overwrite only the enabled byte lanes of the addressed word.
    always_comb begin
        line_o = line_i;
        for (int b = 0; b < ByteLanes; b++) begin
            if (be_i[b]) begin
                line_o[word_base + 32'(b) * 8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_line_responder.sv
// Single-entry write-back line buffer serving the core data port.
// Optional DMEM_LINE_STATS_EN adds saturating hit/miss counters.
module dmem_line_responder
    import dmem_line_pkg::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       mem_address_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [3:0]        mem_byte_enable_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_resp_o,
    output logic [31:0]       pmem_address_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic [BEAT_W-1:0] pmem_wdata_o,
    input  logic [BEAT_W-1:0] pmem_rdata_i,
    input  logic              pmem_resp_i
`ifdef DMEM_LINE_STATS_EN
    ,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
`endif
);

    localparam int unsigned LineW = BEATS * BEAT_W;
    localparam int unsigned LbW   = line_byte_w(BEATS, BEAT_W);
    localparam int unsigned OffW  = word_off_w(BEATS, BEAT_W);
    localparam int unsigned TagW  = tag_w(BEATS, BEAT_W);
    localparam int unsigned CntW  = $clog2(BEATS);
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    dmem_state_t     state_q, state_d;
    logic            valid_q, valid_d;
    logic            dirty_q, dirty_d;
    logic [TagW-1:0] tag_q, tag_d;
    logic [TagW-1:0] miss_tag_q, miss_tag_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [LineW-1:0] line_q;

    logic [TagW-1:0]  req_tag;
    logic [OffW-1:0]  req_off;
    logic             req, hit;
    logic [LineW-1:0] merged_line;
    logic [31:0]      rword;
    logic [31:0]      beat_base;
    logic             line_wr_en, beat_wr_en, fill_done, hit_evt, miss_evt;
    logic             unused_addr;

    assign req_tag     = mem_address_i[31:LbW];
    assign req_off     = mem_address_i[LbW-1:2];
    assign unused_addr = ^mem_address_i[1:0];
    assign req         = mem_read_i | mem_write_i;
    assign hit         = valid_q && (tag_q == req_tag);
    assign beat_base   = 32'(cnt_q) * BEAT_W;

    line_merge #(
        .LineW (LineW),
        .OffW  (OffW)
    ) u_line_merge (
        .line_i     (line_q),
        .word_off_i (req_off),
        .be_i       (mem_byte_enable_i),
        .wdata_i    (mem_wdata_i),
        .line_o     (merged_line),
        .rword_o    (rword)
    );

    // Next-state logic; both read and write set means write.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        miss_tag_d = miss_tag_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        line_wr_en = 1'b0;
        beat_wr_en = 1'b0;
        fill_done  = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        state_d = StResp;
                        hit_evt = 1'b1;
                        if (mem_write_i) begin
                            line_wr_en = 1'b1;
                            dirty_d    = 1'b1;
                        end else begin
                            rdata_d = rword;
                        end
                    end else begin
                        miss_evt   = 1'b1;
                        miss_tag_d = req_tag;
                        state_d    = dirty_q ? StWb : StFill;
                    end
                end
            end
            StResp: state_d = StIdle;
            StWb: begin
                if (pmem_resp_i) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) begin
                        cnt_d   = '0;
                        dirty_d = 1'b0;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (pmem_resp_i) begin
                    beat_wr_en = 1'b1;
                    cnt_d      = cnt_q + CntW'(1);
                    if (cnt_q == LastBeat) begin
                        cnt_d     = '0;
                        valid_d   = 1'b1;
                        tag_d     = miss_tag_q;
                        fill_done = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            tag_q      <= '0;
            miss_tag_q <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            tag_q      <= tag_d;
            miss_tag_q <= miss_tag_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    // Line storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (line_wr_en) begin
            line_q <= merged_line;
        end else if (beat_wr_en) begin
            line_q[beat_base +: BEAT_W] <= pmem_rdata_i;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_rdata_o    = rdata_q;
        mem_resp_o     = (state_q == StResp);
        pmem_read_o    = (state_q == StFill);
        pmem_write_o   = (state_q == StWb);
        pmem_address_o = '0;
        pmem_wdata_o   = '0;
        if (state_q == StWb) begin
            pmem_address_o = {tag_q, {LbW{1'b0}}};
            pmem_wdata_o   = line_q[beat_base +: BEAT_W];
        end else if (state_q == StFill) begin
            pmem_address_o = {miss_tag_q, {LbW{1'b0}}};
        end
    end

`ifdef DMEM_LINE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        refill_q;

    // The completion that follows a fill is part of the miss, not a new hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refill_q   <= 1'b0;
        end else begin
            refill_q <= fill_done;
            if (hit_evt && !refill_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = fill_done ^ hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder with a burst physical-memory model.
module tb_dmem_line_responder;

    localparam int unsigned BEATS  = 4;
    localparam int unsigned BEAT_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       mem_address;
    logic              mem_read, mem_write;
    logic [3:0]        mem_byte_enable;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              mem_resp;
    logic [31:0]       pmem_address;
    logic              pmem_read, pmem_write;
    logic [BEAT_W-1:0] pmem_wdata, pmem_rdata;
    logic              pmem_resp;
`ifdef DMEM_LINE_STATS_EN
    logic [31:0]       hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dmem_line_responder #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .mem_address_i     (mem_address),
        .mem_read_i        (mem_read),
        .mem_write_i       (mem_write),
        .mem_byte_enable_i (mem_byte_enable),
        .mem_wdata_i       (mem_wdata),
        .mem_rdata_o       (mem_rdata),
        .mem_resp_o        (mem_resp),
        .pmem_address_o    (pmem_address),
        .pmem_read_o       (pmem_read),
        .pmem_write_o      (pmem_write),
        .pmem_wdata_o      (pmem_wdata),
        .pmem_rdata_i      (pmem_rdata),
        .pmem_resp_i       (pmem_resp)
`ifdef DMEM_LINE_STATS_EN
        ,
        .hit_count_o       (hit_count),
        .miss_count_o      (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: word i of line L holds ((L>>12)-1)<<16 | (i+1) until written back.
    logic [63:0] mem_q [int unsigned];
    int          rd_beats = 0;
    int          wr_beats = 0;
    int          mbeat    = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [63:0] wb_data [BEATS];
    bit          both_seen = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] line, input int i);
        return (((line >> 12) - 32'd1) << 16) | 32'(i + 1);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] line, input int beat);
        int unsigned key;
        key = line + 32'(beat * 8);
        if (mem_q.exists(key)) return mem_q[key];
        return {init_word(line, 2 * beat + 1), init_word(line, 2 * beat)};
    endfunction

    // One beat per cycle while a burst is requested; beat consumed at the next posedge.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                mbeat     = 0;
            end else if (pmem_read) begin
                pmem_resp    = 1'b1;
                pmem_rdata   = mem_rd(pmem_address, mbeat);
                last_rd_addr = pmem_address;
                rd_beats++;
                mbeat = (mbeat + 1) % BEATS;
            end else if (pmem_write) begin
                pmem_resp = 1'b1;
                mem_q[pmem_address + 32'(mbeat * 8)] = pmem_wdata;
                wb_data[mbeat] = pmem_wdata;
                last_wr_addr   = pmem_address;
                wr_beats++;
                mbeat = (mbeat + 1) % BEATS;
            end else begin
                pmem_resp = 1'b0;
            end
        end
    end

    // Issue a request at a negedge, wait for mem_resp, then drop it and confirm a single pulse.
    task automatic do_req(input logic [31:0] addr, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rdata, output int lat);
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_resp && lat < 100);
        check_eq("resp_seen", mem_resp, 1);
        rdata     = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check_eq("resp_single", mem_resp, 0);
    endtask

    logic [31:0] rd;
    int          lat, b_rd, b_wr, n;

    initial begin
        rst_n           = 1'b0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_mem_resp", mem_resp, 0);
        check_eq("rst_mem_rdata", mem_rdata, 0);
        check_eq("rst_pmem_read", pmem_read, 0);
        check_eq("rst_pmem_write", pmem_write, 0);
        check_eq("rst_pmem_address", pmem_address, 0);
        check_eq("rst_pmem_wdata", pmem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read miss, clean.
        b_rd = rd_beats; b_wr = wr_beats;
        do_req(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("cold_rdata", rd, 32'h0000_0002);
        check_eq("cold_lat", lat, 6);
        check_eq("cold_rd_beats", rd_beats - b_rd, 4);
        check_eq("cold_wr_beats", wr_beats - b_wr, 0);
        check_eq("cold_fill_addr", last_rd_addr, 32'h0000_1000);

        // Write hit, then read it back.
        do_req(32'h0000_1004, 1'b0, 1'b1, 4'b0011, 32'hAAAA_BBBB, rd, lat);
        check_eq("wr_lat", lat, 1);
        check_eq("wr_rdata_hold", rd, 32'h0000_0002);
        do_req(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("hit_rdata", rd, 32'h0000_BBBB);
        check_eq("hit_lat", lat, 1);

        // Dirty miss: write-back then fill.
        b_rd = rd_beats; b_wr = wr_beats;
        do_req(32'h0000_2000, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("wb_lat", lat, 10);
        check_eq("wb_addr", last_wr_addr, 32'h0000_1000);
        check_eq("wb_beat0", wb_data[0], 64'h0000_BBBB_0000_0001);
        check_eq("wb_wr_beats", wr_beats - b_wr, 4);
        check_eq("wb_rd_beats", rd_beats - b_rd, 4);
        check_eq("wb_fill_addr", last_rd_addr, 32'h0000_2000);
        check_eq("wb_rdata", rd, 32'h0001_0001);

        // Read and write together on a hit acts as a write.
        do_req(32'h0000_2008, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, rd, lat);
        check_eq("rw_lat", lat, 1);
        do_req(32'h0000_2008, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("rw_readback", rd, 32'hDEAD_BEEF);
        b_rd = rd_beats; b_wr = wr_beats;
        do_req(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("rw_dirty_lat", lat, 10);
        check_eq("rw_dirty_wr_beats", wr_beats - b_wr, 4);
        check_eq("rw_wb_addr", last_wr_addr, 32'h0000_2000);
        check_eq("rw_wb_beat1", wb_data[1], 64'h0001_0004_DEAD_BEEF);
        check_eq("roundtrip_rdata", rd, 32'h0000_BBBB);

        // Reset in the middle of a fill.
        mem_address = 32'h0000_3000;
        mem_read    = 1'b1;
        b_rd = rd_beats;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((rd_beats - b_rd) < 2 && n < 50);
        check_eq("fill_reached", rd_beats - b_rd, 2);
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        check_eq("midrst_pmem_read", pmem_read, 0);
        check_eq("midrst_mem_resp", mem_resp, 0);
        check_eq("midrst_mem_rdata", mem_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b_rd = rd_beats; b_wr = wr_beats;
        do_req(32'h0000_1000, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("postrst_lat", lat, 6);
        check_eq("postrst_rd_beats", rd_beats - b_rd, 4);
        check_eq("postrst_wr_beats", wr_beats - b_wr, 0);
        check_eq("postrst_rdata", rd, 32'h0000_0001);

        // Three hits and a second miss after reset.
        do_req(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("s_hit1_rdata", rd, 32'h0000_BBBB);
        do_req(32'h0000_1008, 1'b0, 1'b1, 4'b1100, 32'h1234_5678, rd, lat);
        check_eq("s_hit2_lat", lat, 1);
        do_req(32'h0000_1008, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("s_hit3_rdata", rd, 32'h1234_0003);
        b_wr = wr_beats;
        do_req(32'h0000_4000, 1'b1, 1'b0, 4'h0, 32'h0, rd, lat);
        check_eq("s_miss_lat", lat, 10);
        check_eq("s_miss_wr_beats", wr_beats - b_wr, 4);
        check_eq("s_miss_rdata", rd, 32'h0003_0001);
`ifdef DMEM_LINE_STATS_EN
        check_eq("hit_count", hit_count, 3);
        check_eq("miss_count", miss_count, 2);
`endif
        check_eq("rw_exclusive", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
Responder end of the core's data-memory port. It serves the core's word-level mem_read/mem_write/mem_byte_enable requests and answers with mem_resp/mem_rdata. It holds one line buffer (a single-entry write-back cache). Misses are filled from physical memory over a burst interface. Dirty lines are written back over the same interface before the fill. It sits between the core's load/store stage and the physical-memory model or arbiter.

Parameters:
BEATS, 4, beats per line on the physical-memory interface; power of two, ≥2
BEAT_W, 64, bits per beat; LINE_W = BEATS*BEAT_W; BEAT_W multiple of 32

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
mem_address  in  32  core byte address; bits [1:0] ignored
mem_read  in  1  core read request, held until mem_resp
mem_write  in  1  core write request, held until mem_resp
mem_byte_enable  in  4  write byte lanes
mem_wdata  in  32  write data
mem_rdata  out  32  read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  32  line-aligned physical address
pmem_read  out  1  burst read request, held until last beat
pmem_write  out  1  burst write request, held until last beat
pmem_wdata  out  BEAT_W  write beat, beat 0 first (lowest line bits)
pmem_rdata  in  BEAT_W  read beat
pmem_resp  in  1  one pulse per accepted/returned beat

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; valid=0, dirty=0, tag=0, beat counter=0.
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Line data is not reset.
  - Reset mid-burst abandons the burst immediately; dirty data is lost.
- Address split: word offset = addr[log2(LINE_W/8)-1:2]; tag = remaining upper bits.
- States: IDLE, RESP, WB, FILL.
- IDLE, request present (read|write):
  - hit (valid & tag match) -> RESP.
  - miss & dirty -> WB.
  - miss & !dirty -> FILL.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Read: mem_rdata = selected word, registered on entry to RESP.
  - Write: merge enabled bytes into the line and set dirty=1, both on the IDLE->RESP edge; mem_rdata holds its previous value.
  - Next state IDLE. Requests are sampled again only from IDLE, so back-to-back hits complete every 2 cycles; hit latency is request cycle +1.
- WB:
  - pmem_write=1; pmem_address = {old tag, index 0s, byte 0s}.
  - pmem_wdata = beat[counter]; counter increments on each pmem_resp.
  - On the pmem_resp of beat BEATS-1: counter=0, dirty=0, pmem_write drops next cycle, -> FILL.
- FILL:
  - pmem_read=1; pmem_address = new line address.
  - On each pmem_resp, beat[counter] <= pmem_rdata.
  - On the last beat: valid=1, tag=new, -> IDLE. The original request is still held, so it hits next cycle.
  - Miss latency = WB beats + FILL beats + 2 cycles to mem_resp.
- pmem_read and pmem_write are never both 1.
- pmem_resp outside WB/FILL is ignored.
- mem_read and mem_write both 1: treated as write.
- Request dropped by the core before mem_resp: an in-flight WB/FILL completes; no mem_resp is generated afterwards.
- Counter wraps to 0 after BEATS-1; widths are exact, no overflow state.

Optional Feature:
- Macro: DMEM_LINE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on each IDLE->RESP transition taken directly from a hit.
  - miss_count increments on each IDLE->WB or IDLE->FILL transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_line_pkg:
  - state enum dmem_state_t {IDLE, RESP, WB, FILL}
  - localparam helper functions for offset/tag widths from BEATS/BEAT_W
- Sub-module line_merge (combinational): line + word offset + byte_enable + wdata -> merged line, plus word select for reads.
- The FSM, counter and buffer stay in dmem_line_responder.

Test Plan:
- Cold read 0x0000_1004, memory line beat0=0x0000_0002_0000_0001 -> pmem_read at 0x0000_1000, 4 beats, then mem_resp with mem_rdata=0x0000_0002; pmem_write never asserted.
- Write 0x0000_1004, be=4'b0011, wdata=0xAAAA_BBBB after fill -> mem_resp next cycle; read 0x1004 returns 0x0000_BBBB (hit, 1-cycle latency).
- Then read 0x0000_2000 -> WB burst at 0x0000_1000 with beat0=0x0000_BBBB_0000_0001, then FILL at 0x0000_2000, then mem_resp; exactly 8 pmem_resp consumed.
- Reset asserted during FILL beat 2 -> pmem_read=0 and mem_resp=0 in the same cycle; after release, read 0x1000 misses (valid=0).
- mem_read=mem_write=1 on a hit -> line updated as a write, dirty=1, single mem_resp.
- With DMEM_LINE_STATS_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2.
